// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch history table predictor.
`default_nettype none
package bp_pkg;

  localparam int unsigned PC_IDX_LSB = 2;
  localparam int unsigned CNT_MIN    = 0;
  localparam int unsigned CNT_RESET  = 0;

  function automatic int unsigned cnt_max(input int unsigned cnt_bits);
    return (32'd1 << cnt_bits) - 32'd1;
  endfunction

  function automatic int unsigned taken_bit(input int unsigned cnt_bits);
    return cnt_bits - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
// Up/down saturating counter with enable and synchronous active-low reset.
`default_nettype none
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CNT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  output logic [CNT_BITS-1:0] count
);

  localparam logic [CNT_BITS-1:0] MAX_VAL = CNT_BITS'(cnt_max(CNT_BITS));
  localparam logic [CNT_BITS-1:0] MIN_VAL = CNT_BITS'(CNT_MIN);
  localparam logic [CNT_BITS-1:0] RST_VAL = CNT_BITS'(CNT_RESET);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (en) begin
      if (up) begin
        if (count != MAX_VAL) count <= count + CNT_BITS'(1);
      end else begin
        if (count != MIN_VAL) count <= count - CNT_BITS'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bht_predictor.sv
// Branch history table: flop-based saturating counters, bimodal or gshare indexed.
`default_nettype none
module bht_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CNT_BITS   = 2,
  parameter int unsigned GHR_BITS   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           i_pc,
  output logic                  o_predict_taken,
  output logic [INDEX_BITS-1:0] o_pred_idx,
  input  logic                  i_upd_valid,
  input  logic [INDEX_BITS-1:0] i_upd_idx,
  input  logic                  i_upd_taken
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TBIT    = taken_bit(CNT_BITS);

  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] idx;
  logic [CNT_BITS-1:0]   cnt [ENTRIES];
  logic                  unused_pc_bits;

  generate
    if (GHR_BITS == 0) begin : g_no_ghr
      assign ghr_ext = '0;
    end else begin : g_ghr
      logic [GHR_BITS-1:0] ghr;
      // Non-speculative history: only resolved branches shift in.
      if (GHR_BITS == 1) begin : g_ghr1
        always_ff @(posedge clk) begin
          if (!rst_n)           ghr <= '0;
          else if (i_upd_valid) ghr <= i_upd_taken;
        end
      end else begin : g_ghrn
        always_ff @(posedge clk) begin
          if (!rst_n)           ghr <= '0;
          else if (i_upd_valid) ghr <= {ghr[GHR_BITS-2:0], i_upd_taken};
        end
      end
      assign ghr_ext = INDEX_BITS'(ghr);
    end
  endgenerate

  assign idx            = i_pc[INDEX_BITS+PC_IDX_LSB-1:PC_IDX_LSB] ^ ghr_ext;
  assign unused_pc_bits = ^{i_pc[31:INDEX_BITS+PC_IDX_LSB], i_pc[PC_IDX_LSB-1:0]};

  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      bp_sat_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (i_upd_valid && (i_upd_idx == INDEX_BITS'(i))),
        .up    (i_upd_taken),
        .count (cnt[i])
      );
    end
  endgenerate

  assign o_pred_idx      = idx;
  assign o_predict_taken = cnt[idx][TBIT];

endmodule
`default_nettype wire
